// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the LED-matrix display path.
//   DEF_COLS / DEF_ROWS / DEF_ADDR_W : default panel geometry and word address
//                                      width (log2(COLS*ROWS/2))
//   pixel_t                          : 24-bit RGB pixel {r, g, b}
//   frame_writer_state_t             : frame_writer FSM encoding
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int DEF_COLS   = 64;
    localparam int DEF_ROWS   = 32;
    localparam int DEF_ADDR_W = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } frame_writer_state_t;

endpackage

// File: rtl/frame_addr_gen.sv
// -----------------------------------------------------------------------------
// frame_addr_gen
// Raster row/col counters for frame_writer.
//   clk, rst        : clock, asynchronous active-low reset
//   step            : a pixel is consumed at the presented position this cycle
//   sof             : incoming pixel carries start-of-frame; the presented
//                     position becomes (0,0) and counting restarts from there
//   pos_row/pos_col : position the incoming pixel is written to
//   at_origin       : counters currently sit at (0,0) (sof there is no error)
//   last            : presented position is the final pixel of the frame
// -----------------------------------------------------------------------------
module frame_addr_gen
    import display_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             sof,
    output logic [ROW_W-1:0] pos_row,
    output logic [COL_W-1:0] pos_col,
    output logic             at_origin,
    output logic             last
);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic             col_end;

    // sof overrides the running count so the resync pixel lands at (0,0)
    assign pos_row   = sof ? '0 : row_q;
    assign pos_col   = sof ? '0 : col_q;
    assign at_origin = (row_q == '0) && (col_q == '0);
    assign col_end   = (pos_col == COL_W'(COLS - 1));
    assign last      = col_end && (pos_row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (step) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= last ? '0 : pos_row + ROW_W'(1);
            end else begin
                col_q <= pos_col + COL_W'(1);
                row_q <= pos_row;
            end
        end
    end

endmodule

// File: rtl/frame_writer.sv
// -----------------------------------------------------------------------------
// frame_writer
// Writes a raster-ordered RGB pixel stream into the LED-matrix frame buffer.
// Each 48-bit RAM word pairs a top-half pixel [23:0] with the bottom-half
// pixel [47:24] that is shifted out alongside it; each pixel write uses a
// half enable so the other half of the word is left untouched.
//
// Build option: define FRAME_DOUBLE_BUFFER_EN for two banks with a bank swap
// aligned to the display refresh (disp_vsync). Without it there is a single
// bank, rd_bank and the wr_addr bank bit are 0 and disp_vsync is ignored.
//
// Ports
//   clk, rst    : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_sof : pixel stream, s_sof on first pixel
//   wr_en/wr_addr/wr_data/wr_be  : RAM write port, {bank,row,col} address,
//                                  wr_be 01 = top half, 10 = bottom half
//   disp_vsync  : end-of-refresh pulse from the display controller
//   rd_bank     : bank the display controller scans
//   frame_done  : pulse with the write of the final pixel
//   err_sof     : pulse with the write of a pixel whose s_sof came mid-frame
// -----------------------------------------------------------------------------
module frame_writer
    import display_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [23:0]       s_data,
    input  logic              s_sof,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [47:0]       wr_data,
    output logic [1:0]        wr_be,
    input  logic              disp_vsync,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              err_sof
);

    localparam int COL_W     = $clog2(COLS);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int HALF_ROWS = ROWS / 2;
    localparam int HROW_W    = $clog2(HALF_ROWS);

    function automatic logic [47:0] pack_word(input pixel_t pix, input logic bottom);
        return bottom ? {pix, 24'd0} : {24'd0, pix};
    endfunction

    function automatic logic [1:0] half_enable(input logic bottom);
        return bottom ? 2'b10 : 2'b01;
    endfunction

    frame_writer_state_t state, next_state;

    logic             accept;
    logic             step;
    logic             wr_req;
    logic             err_req;
    logic             done_req;
    logic             swap;
    logic [ROW_W-1:0] pos_row;
    logic [COL_W-1:0] pos_col;
    logic             at_origin;
    logic             last;
    logic             wr_bank;
    logic             bottom;
    logic [HROW_W-1:0] half_row;

    // Ready depends on state only; held low while in reset
    assign s_ready = rst && (state != ST_WAIT_SWAP);
    assign accept  = s_valid && s_ready;

    frame_addr_gen #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .sof       (s_sof),
        .pos_row   (pos_row),
        .pos_col   (pos_col),
        .at_origin (at_origin),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        step       = 1'b0;
        wr_req     = 1'b0;
        err_req    = 1'b0;
        done_req   = 1'b0;
        swap       = 1'b0;
        case (state)
            ST_IDLE: begin
                // Non-sof pixels are consumed and discarded until a frame starts
                if (accept && s_sof) begin
                    step       = 1'b1;
                    wr_req     = 1'b1;
                    next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    step    = 1'b1;
                    wr_req  = 1'b1;
                    err_req = s_sof && !at_origin;
                    if (last) begin
                        done_req = 1'b1;
`ifdef FRAME_DOUBLE_BUFFER_EN
                        next_state = ST_WAIT_SWAP;
`else
                        next_state = ST_IDLE;
`endif
                    end
                end
            end
`ifdef FRAME_DOUBLE_BUFFER_EN
            ST_WAIT_SWAP: begin
                if (disp_vsync) begin
                    swap       = 1'b1;
                    next_state = ST_IDLE;
                end
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

`ifdef FRAME_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank <= 1'b0;
        end else if (swap) begin
            rd_bank <= ~rd_bank;
        end
    end
    // Always write the bank the display is not scanning
    assign wr_bank = ~rd_bank;
`else
    logic unused_vsync;
    assign unused_vsync = disp_vsync | swap;
    assign rd_bank      = 1'b0;
    assign wr_bank      = 1'b0;
`endif

    // Bottom-half rows share word addresses with the top half
    assign bottom   = (pos_row >= ROW_W'(HALF_ROWS));
    assign half_row = HROW_W'(bottom ? pos_row - ROW_W'(HALF_ROWS) : pos_row);

    // ---- stage p0: capture accepted pixel and its placement ----
    logic              vld_p0;
    logic              done_p0;
    logic              err_p0;
    pixel_t            pix_p0;
    logic              bottom_p0;
    logic [ADDR_W:0]   addr_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
            err_p0  <= 1'b0;
        end else begin
            vld_p0  <= wr_req;
            done_p0 <= done_req;
            err_p0  <= err_req;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_req) begin
            pix_p0    <= pixel_t'(s_data);
            bottom_p0 <= bottom;
            addr_p0   <= {wr_bank, half_row, pos_col};
        end
    end

    // ---- stage p1: pack into the RAM word and drive the write port ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= 2'b00;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            wr_en      <= vld_p0;
            frame_done <= done_p0;
            err_sof    <= err_p0;
            wr_be      <= vld_p0 ? half_enable(bottom_p0) : 2'b00;
            if (vld_p0) begin
                wr_addr <= addr_p0;
                wr_data <= pack_word(pix_p0, bottom_p0);
            end
        end
    end

endmodule

// File: doc/frame_writer.md
# frame_writer

Upstream stage of the LED-matrix display path. Accepts a raster-ordered 24-bit RGB pixel stream over a valid/ready handshake and writes it into the frame-buffer RAM that the display controller scans. Pixels are packed into 48-bit words so that each word holds the top-half pixel and the bottom-half pixel driven out together on rgb1/rgb2. With double buffering compiled in, the block also owns the bank swap, synchronised to the display's refresh boundary.

## Interface
- COLS, 64, panel columns (power of two)
- ROWS, 32, panel rows; top half = rows 0..ROWS/2-1, bottom half = rest
- ADDR_W, 10, word address width = log2(COLS*ROWS/2)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accepted when s_valid && s_ready
- s_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- s_sof  in  1  marks first pixel of a frame
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W+1  {bank, row[3:0], col[5:0]}; bank bit is 0 when not double-buffered
- wr_data  out  48  {bottom pixel[47:24], top pixel[23:0]}
- wr_be  out  2  half enables: 01 = top, 10 = bottom
- disp_vsync  in  1  one-cycle pulse from display control at end of a full refresh
- rd_bank  out  1  bank the display controller reads
- frame_done  out  1  one-cycle pulse, last pixel written
- err_sof  out  1  one-cycle pulse, s_sof arrived mid-frame

## Operation
- States: IDLE, FILL, WAIT_SWAP.
- IDLE: s_ready=1.
  - Pixels with s_sof=0 are accepted and dropped.
  - A pixel with s_sof=1 is written to (0,0); the block then enters FILL.
- FILL: s_ready=1. Each accepted pixel is written at the current (row, col), then col increments.
  - col wraps at COLS-1 and increments row.
- Packing: for row < ROWS/2, data goes to [23:0] with wr_be=01. Otherwise it goes to [47:24] with wr_be=10 and row index row-ROWS/2. The unused half is driven 0.
- Last pixel (row ROWS-1, col COLS-1): written; frame_done pulses in the same cycle as its wr_en. The block then goes to WAIT_SWAP (double-buffered) or IDLE (single).
- s_sof in FILL at (row,col) ≠ (0,0):
  - err_sof pulses.
  - The pixel is written to (0,0) and counting restarts from there.
  - The partial frame is abandoned and no frame_done is issued.
- s_sof in FILL at (0,0) is normal, with no error.
- WAIT_SWAP: s_ready=0.
  - On disp_vsync: rd_bank toggles, the write bank becomes the new ~rd_bank, and the block goes to IDLE.
  - A disp_vsync in the same cycle the last pixel is accepted is ignored; the swap waits for the next pulse.
- disp_vsync outside WAIT_SWAP has no effect.

## Timing
- Reset values:
  - state IDLE, row=col=0, rd_bank=0.
  - wr_en=0, wr_addr=0, wr_data=0, wr_be=0.
  - frame_done=0, err_sof=0.
  - s_ready=0 while rst is low.
- s_ready is a function of state only, never of s_valid.
- Latency: a pixel accepted at edge N gives wr_en/wr_addr/wr_data/wr_be registered and valid for one cycle after edge N+1. frame_done and err_sof are aligned with that wr_en.
- Throughput is one pixel per clock in FILL.
- Swap: rd_bank changes at the edge after the disp_vsync cycle; s_ready rises in that same cycle.
- Reset mid-frame: the frame is discarded and rd_bank returns to 0.

## Configuration
- FRAME_DOUBLE_BUFFER_EN defined:
  - Two banks and the WAIT_SWAP state.
  - wr_addr MSB = ~rd_bank.
- FRAME_DOUBLE_BUFFER_EN undefined:
  - Single bank; WAIT_SWAP is removed and the block goes from the last pixel straight to IDLE.
  - rd_bank and wr_addr MSB are tied 0; disp_vsync is ignored.
  - Tearing is accepted.

## Structure
- Shared package display_pkg holds:
  - COLS, ROWS, ADDR_W defaults.
  - pixel_t (24-bit RGB struct).
  - frame_writer_state_t enum.
- One sub-module, frame_addr_gen: the row/col counters with wrap, last-pixel flag and sof restart. The FSM, packing and swap logic stay in frame_writer.

## Test plan
- Full frame: sof followed by 2048 pixels with data = index, streamed without gaps. Expect 2048 writes with the correct address and half in each. Pixel 0 → addr 0, be=01, data[23:0]=0. Pixel 1024 → addr 0, be=10, data[47:24]=1024. frame_done pulses exactly once, with the final write.
- Pre-sof garbage: 5 pixels with s_sof=0 in IDLE. Expect all accepted, wr_en stays 0.
- Mid-frame resync: sof again at pixel 100. Expect err_sof, and that pixel written to addr 0. The next frame_done comes only after 2047 further pixels.
- Swap (macro defined): complete a frame, then hold s_valid. Expect s_ready=0 until disp_vsync. The cycle after the pulse, rd_bank=1, and the next frame writes with wr_addr MSB=0.
- Simultaneous events: disp_vsync in the same cycle as the last-pixel acceptance → no swap. A later vsync → swap.
- Async reset asserted mid-FILL: all outputs go to their reset values immediately, without waiting for a clock edge. After release, the block waits for sof.
